// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix multiplier.
// FSM state encoding and step-count helper used by seq_mult_radix.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    function automatic int mult_steps(int w, int d);
        return w / d;
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Partial product of a 2*WIDTH multiplicand and one DIGIT_BITS-wide multiplier digit.
// Purely combinational; the D=1 case collapses to an AND mask.
module mult_digit_pp #(
    parameter int WIDTH2     = 16,
    parameter int DIGIT_BITS = 1
) (
    input  logic [WIDTH2-1:0]     i_mcand,
    input  logic [DIGIT_BITS-1:0] i_digit,
    output logic [WIDTH2-1:0]     o_pp
);

    if (DIGIT_BITS == 1) begin : g_and
        assign o_pp = i_mcand & {WIDTH2{i_digit[0]}};
    end else begin : g_sum
        // Shifted copies never overflow WIDTH2: the caller keeps mcand below 2^(WIDTH2-DIGIT_BITS).
        always_comb begin
            o_pp = '0;
            for (int i = 0; i < DIGIT_BITS; i++) begin
                o_pp = o_pp + ((i_mcand << i) & {WIDTH2{i_digit[i]}});
            end
        end
    end

endmodule

// File: rtl/seq_mult_radix.sv
// Sequential shift-add multiplier, full 2*WIDTH unsigned product, DIGIT_BITS bits per cycle.
// Latency WIDTH/DIGIT_BITS cycles; SEQ_MULT_EARLY_TERM_EN stops once the multiplier is exhausted.
// One op in flight: in_ready only in IDLE; product/out_valid held until out_ready.
module seq_mult_radix
    import mult_pkg::*;
#(
    parameter int WIDTH      = 4096,
    parameter int DIGIT_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NUM_STEPS = mult_steps(WIDTH, DIGIT_BITS);
    localparam int CNT_W     = $clog2(NUM_STEPS + 1);
    localparam int W2        = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    if (WIDTH % DIGIT_BITS != 0) begin : g_bad_cfg
        $fatal(1, "seq_mult_radix: WIDTH must be a multiple of DIGIT_BITS");
    end

    mult_state_e        r_state;
    logic [W2-1:0]      r_acc;
    logic [W2-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;
    logic [W2-1:0]      r_product;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [W2-1:0]      w_pp;
    logic [W2-1:0]      w_acc_next;

    mult_digit_pp #(
        .WIDTH2     (W2),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_pp (
        .i_mcand (r_mcand),
        .i_digit (r_mplier[DIGIT_BITS-1:0]),
        .o_pp    (w_pp)
    );

    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_count     <= '0;
            r_product   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc      <= '0;
                        r_mcand    <= {{WIDTH{1'b0}}, a};
                        r_mplier   <= b;
                        r_count    <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                    if (r_mplier == '0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_product   <= r_acc;
                    end else
`endif
                    begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << DIGIT_BITS;
                        r_mplier <= r_mplier >> DIGIT_BITS;
                        r_count  <= r_count + 1'b1;
                        // Final digit: publish the sum that includes this step's partial product.
                        if (r_count == LAST_STEP) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_product   <= w_acc_next;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_mult_radix.sv
// Self-checking bench: three WIDTH=8 instances (D=1,2,4) plus the default 4096/1 instance.
module tb_seq_mult_radix;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [2:0]        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [2:0][7:0]   a8, b8;
    logic [2:0][15:0]  prod8;

    logic              in_valid_big, in_ready_big, out_valid_big, out_ready_big, busy_big;
    logic [4095:0]     a_big, b_big;
    logic [8191:0]     prod_big;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g8
        seq_mult_radix #(.WIDTH(8), .DIGIT_BITS(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid8[g]),
            .in_ready  (in_ready8[g]),
            .a         (a8[g]),
            .b         (b8[g]),
            .out_valid (out_valid8[g]),
            .out_ready (out_ready8[g]),
            .product   (prod8[g]),
            .busy      (busy8[g])
        );
    end

    seq_mult_radix u_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_big),
        .in_ready  (in_ready_big),
        .a         (a_big),
        .b         (b_big),
        .out_valid (out_valid_big),
        .out_ready (out_ready_big),
        .product   (prod_big),
        .busy      (busy_big)
    );

    // Reference latency: full step count, or shortened when early termination is built in.
    function automatic int exp_lat(logic [4095:0] bv, int w, int d);
        int steps;
        int nb;
        int e;
        steps = w / d;
        nb = 0;
        for (int i = 0; i < w; i++) if (bv[i]) nb = i + 1;
        e = 1 + (nb + d - 1) / d;
`ifdef SEQ_MULT_EARLY_TERM_EN
        return (e < steps) ? e : steps;
`else
        return (e < 0) ? e : steps;
`endif
    endfunction

    // Drives one op into instance k and reports what it observed; called at posedge+1 with k idle.
    task automatic run8(input int k, input logic [7:0] av, input logic [7:0] bv, input int hold,
                        output logic [15:0] prod, output int lat, output int ctrl_bad,
                        output int stable_bad, output int post_bad);
        ctrl_bad = 0; stable_bad = 0; post_bad = 0; lat = -1;
        a8[k] = av; b8[k] = bv; out_ready8[k] = 1'b0; in_valid8[k] = 1'b1;
        @(posedge clk); #1;
        in_valid8[k] = 1'b0;
        a8[k] = 8'($urandom); b8[k] = 8'($urandom);
        for (int c = 1; c <= 64; c++) begin
            if (in_ready8[k] !== 1'b0 || busy8[k] !== 1'b1) ctrl_bad++;
            @(posedge clk); #1;
            if (out_valid8[k] === 1'b1) begin
                lat = c;
                break;
            end
        end
        prod = prod8[k];
        if (lat < 0) return;
        for (int h = 0; h < hold; h++) begin
            if (in_ready8[k] !== 1'b0 || busy8[k] !== 1'b1) ctrl_bad++;
            @(posedge clk); #1;
            if (out_valid8[k] !== 1'b1 || prod8[k] !== prod) stable_bad++;
        end
        if (in_ready8[k] !== 1'b0 || busy8[k] !== 1'b1) ctrl_bad++;
        out_ready8[k] = 1'b1;
        @(posedge clk); #1;
        out_ready8[k] = 1'b0;
        if (out_valid8[k] !== 1'b0 || in_ready8[k] !== 1'b1 || busy8[k] !== 1'b0) post_bad++;
        if (prod8[k] !== prod) post_bad++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = '0; out_ready8 = '0; a8 = '0; b8 = '0;
        in_valid_big = 1'b0; out_ready_big = 1'b0; a_big = '0; b_big = '0;
        #12;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready8[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready8[k]); end
            checks++;
            if (out_valid8[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid8[k]); end
            checks++;
            if (busy8[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy8[k]); end
            checks++;
            if (prod8[k] !== 16'h0) begin errors++; $display("FAIL reset_product[%0d]: got %h expected 0", k, prod8[k]); end
        end
        checks++;
        if (in_ready_big !== 1'b1 || out_valid_big !== 1'b0 || busy_big !== 1'b0 || prod_big !== '0) begin
            errors++;
            $display("FAIL reset_big: got in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready_big, out_valid_big, busy_big);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_d2_allones();
        logic [15:0] p; int lat, cb, sb, pb;
        run8(1, 8'hFF, 8'hFF, 3, p, lat, cb, sb, pb);
        checks++;
        if (p !== 16'hFE01) begin errors++; $display("FAIL d2_allones_product: got %h expected fe01", p); end
        checks++;
        if (lat != exp_lat(4096'(8'hFF), 8, 2)) begin errors++; $display("FAIL d2_allones_latency: got %0d expected %0d", lat, exp_lat(4096'(8'hFF), 8, 2)); end
        checks++;
        if (sb != 0) begin errors++; $display("FAIL d2_hold_stable: got %0d unstable cycles expected 0", sb); end
        checks++;
        if (cb != 0 || pb != 0) begin errors++; $display("FAIL d2_handshake: got ctrl_bad=%0d post_bad=%0d expected 0 0", cb, pb); end
    endtask

    task automatic test_d1_basic();
        logic [15:0] p; int lat, cb, sb, pb;
        run8(0, 8'h0D, 8'h0B, 0, p, lat, cb, sb, pb);
        checks++;
        if (p !== 16'h008F) begin errors++; $display("FAIL d1_basic_product: got %h expected 008f", p); end
        checks++;
        if (lat != exp_lat(4096'(8'h0B), 8, 1)) begin errors++; $display("FAIL d1_basic_latency: got %0d expected %0d", lat, exp_lat(4096'(8'h0B), 8, 1)); end
        checks++;
        if (cb != 0) begin errors++; $display("FAIL d1_busy_in_ready: got %0d bad cycles expected 0", cb); end
        checks++;
        if (pb != 0) begin errors++; $display("FAIL d1_return_idle: got %0d bad expected 0", pb); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [15:0] p1, p2;
        t1 = -1; t2 = -1; p1 = '0; p2 = '0;
        a8[0] = 8'h03; b8[0] = 8'h05; out_ready8[0] = 1'b1; in_valid8[0] = 1'b1;
        @(posedge clk); #1;
        a8[0] = 8'h10; b8[0] = 8'h10;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (out_valid8[0] === 1'b1) begin t1 = c; p1 = prod8[0]; break; end
        end
        checks++;
        if (p1 !== 16'h000F || t1 != exp_lat(4096'(8'h05), 8, 1)) begin
            errors++; $display("FAIL b2b_first: got product %h after %0d cycles expected 000f after %0d", p1, t1, exp_lat(4096'(8'h05), 8, 1));
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid8[0] !== 1'b0 || in_ready8[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid8[0], in_ready8[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready8[0] !== 1'b0 || busy8[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_second_accept: got in_ready=%b busy=%b expected 0 1", in_ready8[0], busy8[0]);
        end
        in_valid8[0] = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (out_valid8[0] === 1'b1) begin t2 = c; p2 = prod8[0]; break; end
        end
        checks++;
        if (p2 !== 16'h0100 || t2 != exp_lat(4096'(8'h10), 8, 1)) begin
            errors++; $display("FAIL b2b_second: got product %h after %0d cycles expected 0100 after %0d", p2, t2, exp_lat(4096'(8'h10), 8, 1));
        end
        @(posedge clk); #1;
        out_ready8[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p; int lat, cb, sb, pb;
        a8[0] = 8'h77; b8[0] = 8'h99; in_valid8[0] = 1'b1;
        @(posedge clk); #1;
        in_valid8[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid8[0] !== 1'b0 || in_ready8[0] !== 1'b1 || busy8[0] !== 1'b0) begin
            errors++; $display("FAIL midrun_reset_ctrl: got out_valid=%b in_ready=%b busy=%b expected 0 1 0", out_valid8[0], in_ready8[0], busy8[0]);
        end
        checks++;
        if (prod8[0] !== 16'h0) begin errors++; $display("FAIL midrun_reset_product: got %h expected 0", prod8[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(0, 8'h77, 8'h99, 1, p, lat, cb, sb, pb);
        checks++;
        if (p !== 16'(8'h77 * 16'h99) || lat != exp_lat(4096'(8'h99), 8, 1)) begin
            errors++; $display("FAIL midrun_fresh_op: got %h after %0d cycles expected %h after %0d", p, lat, 16'(8'h77 * 16'h99), exp_lat(4096'(8'h99), 8, 1));
        end
    endtask

    task automatic test_early_term();
        logic [15:0] p; int lat, cb, sb, pb;
        run8(0, 8'h5A, 8'h00, 0, p, lat, cb, sb, pb);
        checks++;
        if (p !== 16'h0 || lat != exp_lat(4096'(8'h00), 8, 1)) begin
            errors++; $display("FAIL early_b0: got %h after %0d cycles expected 0000 after %0d", p, lat, exp_lat(4096'(8'h00), 8, 1));
        end
        run8(0, 8'hAB, 8'h01, 0, p, lat, cb, sb, pb);
        checks++;
        if (p !== 16'h00AB || lat != exp_lat(4096'(8'h01), 8, 1)) begin
            errors++; $display("FAIL early_b1: got %h after %0d cycles expected 00ab after %0d", p, lat, exp_lat(4096'(8'h01), 8, 1));
        end
    endtask

    task automatic test_random_w8();
        logic [7:0] av, bv;
        logic [15:0] p; int lat, cb, sb, pb, hold;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 24; n++) begin
                case (n)
                    0: begin av = 8'h00; bv = 8'h00; end
                    1: begin av = 8'hFF; bv = 8'hFF; end
                    2: begin av = 8'h01; bv = 8'hFF; end
                    3: begin av = 8'h80; bv = 8'h80; end
                    default: begin av = 8'($urandom); bv = 8'($urandom); end
                endcase
                hold = $urandom_range(0, 2);
                run8(k, av, bv, hold, p, lat, cb, sb, pb);
                checks++;
                if (p !== 16'(av) * 16'(bv)) begin
                    errors++; $display("FAIL rand8_product d=%0d: %h*%h got %h expected %h", 1 << k, av, bv, p, 16'(av) * 16'(bv));
                end
                checks++;
                if (lat != exp_lat(4096'(bv), 8, 1 << k)) begin
                    errors++; $display("FAIL rand8_latency d=%0d b=%h: got %0d expected %0d", 1 << k, bv, lat, exp_lat(4096'(bv), 8, 1 << k));
                end
                checks++;
                if (cb != 0 || sb != 0 || pb != 0) begin
                    errors++; $display("FAIL rand8_handshake d=%0d: got ctrl=%0d stable=%0d post=%0d expected 0 0 0", 1 << k, cb, sb, pb);
                end
            end
        end
    endtask

    task automatic test_big();
        logic [4095:0] av, bv;
        logic [8191:0] expv;
        int lat, elat;
        for (int n = 0; n < 7; n++) begin
            if (n == 0) begin
                av = '1; bv = '1;
            end else begin
                for (int i = 0; i < 128; i++) begin
                    av[i*32 +: 32] = $urandom;
                    bv[i*32 +: 32] = $urandom;
                end
            end
            expv = 8192'(av) * 8192'(bv);
            elat = exp_lat(bv, 4096, 1);
            a_big = av; b_big = bv; out_ready_big = 1'b0; in_valid_big = 1'b1;
            @(posedge clk); #1;
            in_valid_big = 1'b0;
            lat = -1;
            for (int c = 1; c <= 4200; c++) begin
                @(posedge clk); #1;
                if (out_valid_big === 1'b1) begin lat = c; break; end
            end
            checks++;
            if (prod_big !== expv) begin
                errors++; $display("FAIL big_product op %0d: got low word %h expected %h", n, prod_big[63:0], expv[63:0]);
            end
            checks++;
            if (lat != elat) begin errors++; $display("FAIL big_latency op %0d: got %0d expected %0d", n, lat, elat); end
            out_ready_big = 1'b1;
            @(posedge clk); #1;
            out_ready_big = 1'b0;
            checks++;
            if (in_ready_big !== 1'b1 || out_valid_big !== 1'b0) begin
                errors++; $display("FAIL big_return_idle op %0d: got in_ready=%b out_valid=%b expected 1 0", n, in_ready_big, out_valid_big);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_d2_allones();
        test_d1_basic();
        test_back_to_back();
        test_reset_mid_run();
        test_early_term();
        test_random_w8();
        test_big();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
